// File: rtl/result_led_driver.sv
// Output stage of the 7-bit add/sub lab design: debounces the {carry,sum}
// result, flashes the LEDs blank on each new value and blinks LED7 on carry.
module result_led_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FLASH_CYCLES  = 5_000_000,
    parameter int BLINK_HALF    = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sum,
    input  logic       carry,
    output logic [7:0] led,
    output logic       new_result
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FMAX = FW'(FLASH_CYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);

    typedef enum logic {
        SHOW,
        FLASH
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cand_q, cand_d;
    logic [7:0]    shown_q, shown_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          pulse_q, pulse_d;

    logic [7:0]    raw;
    logic          accept;

    assign raw = {carry, sum};

    // Candidate must match for SETTLE_CYCLES consecutive edges to be accepted
    always_comb begin
        cand_d = cand_q;
        scnt_d = scnt_q;
        if (raw != cand_q) begin
            cand_d = raw;
            scnt_d = '0;
        end else if (scnt_q != SMAX) begin
            scnt_d = scnt_q + SW'(1);
        end
    end

    assign accept = (raw == cand_q) && (scnt_q == SMAX) && (cand_q != shown_q);

    always_comb begin
        state_d = state_q;
        shown_d = shown_q;
        flash_d = flash_q;
        blink_d = blink_q;
        phase_d = phase_q;
        pulse_d = 1'b0;
        unique case (state_q)
            SHOW: begin
                if (blink_q == BMAX) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            FLASH: begin
                if (flash_q == FMAX) begin
                    state_d = SHOW;
                    blink_d = '0;
                    phase_d = 1'b1;
                end else begin
                    flash_d = flash_q + FW'(1);
                end
            end
            default: state_d = SHOW;
        endcase
        // A new accept overrides flash expiry and restarts the blank period
        if (accept) begin
            shown_d = cand_q;
            pulse_d = 1'b1;
            state_d = FLASH;
            flash_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
            cand_q  <= '0;
            shown_q <= '0;
            scnt_q  <= '0;
            flash_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            shown_q <= shown_d;
            scnt_q  <= scnt_d;
            flash_q <= flash_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
        end
    end

    assign led = (state_q == FLASH) ? 8'h00
                                    : {shown_q[7] & phase_q, shown_q[6:0]};
    assign new_result = pulse_q;

endmodule

// File: tb/tb_result_led_driver.sv
// Randomized bench for result_led_driver against a timeline-level model
// of the settle, flash and blink behaviour.
module tb_result_led_driver;

    localparam int SETTLE = 4;
    localparam int FLASH  = 8;
    localparam int BH     = 5;

    logic       clk;
    logic       rst_n;
    logic [6:0] sum;
    logic       carry;
    logic [7:0] led;
    logic       new_result;

    int n_chk;
    int n_err;

    logic [7:0] m_shown;
    logic [7:0] m_prev;
    int         m_run;
    int         m_blank;
    int         m_t;
    logic       m_pulse;

    result_led_driver #(
        .SETTLE_CYCLES(SETTLE),
        .FLASH_CYCLES (FLASH),
        .BLINK_HALF   (BH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum       (sum),
        .carry     (carry),
        .led       (led),
        .new_result(new_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_shown = '0;
        m_prev  = '0;
        m_run   = 0;
        m_blank = 0;
        m_t     = 0;
        m_pulse = 1'b0;
    endtask

    // Accept when the value has been seen on SETTLE+1 consecutive edges
    task automatic m_edge();
        logic [7:0] raw;
        raw = {carry, sum};
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_run  = (raw == m_prev) ? m_run + 1 : 1;
        m_prev = raw;
        if (m_run > SETTLE && raw != m_shown) begin
            m_shown = raw;
            m_pulse = 1'b1;
            m_blank = FLASH;
        end else begin
            m_pulse = 1'b0;
            if (m_blank > 0) begin
                m_blank--;
                if (m_blank == 0) m_t = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    function automatic logic [7:0] m_led();
        logic lit;
        lit = ((m_t / BH) % 2) == 0;
        if (m_blank > 0) return 8'h00;
        return {m_shown[7] & lit, m_shown[6:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
        chk("led", 32'(led), 32'(m_led()));
        chk("pulse", 32'(new_result), 32'(m_pulse));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Returns the edge count (from 1) on which the pulse appeared, 0 if none
    task automatic wait_pulse(input int bound, output int lat);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            cyc();
            if (new_result && lat == 0) begin
                lat = i;
                return;
            end
        end
    endtask

    initial begin
        int lat;
        int hold;
        logic [7:0] v;
        n_chk = 0;
        n_err = 0;
        m_reset();
        rst_n = 1'b0;
        sum   = 7'h00;
        carry = 1'b0;
        #2;
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_pulse", 32'(new_result), 32'h0);
        run(3);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle zero input
        run(50);

        // 2: latency and flash length
        sum = 7'h15;
        wait_pulse(20, lat);
        chk("lat_15", 32'(lat), 32'(SETTLE + 1));
        run(FLASH - 1);
        chk("blank_end", 32'(led), 32'h00);
        cyc();
        chk("show_15", 32'(led), 32'h15);
        run(10);

        // 3: short glitch ignored
        sum = 7'h00;
        run(2);
        sum = 7'h15;
        run(10);
        chk("glitch", 32'(led), 32'h15);

        // 4: carry blink
        sum   = 7'h03;
        carry = 1'b1;
        wait_pulse(20, lat);
        chk("lat_83", 32'(lat), 32'(SETTLE + 1));
        run(FLASH);
        chk("blink_on", 32'(led), 32'h83);
        run(BH);
        chk("blink_off", 32'(led), 32'h03);
        run(BH);
        chk("blink_on2", 32'(led), 32'h83);

        // 5: accept during flash restarts it
        sum   = 7'h00;
        carry = 1'b0;
        wait_pulse(20, lat);
        sum   = 7'h03;
        carry = 1'b1;
        wait_pulse(20, lat);
        run(2);
        sum   = 7'h2A;
        carry = 1'b0;
        wait_pulse(20, lat);
        chk("lat_2a", 32'(lat), 32'(SETTLE + 1));
        run(FLASH - 1);
        chk("reflash", 32'(led), 32'h00);
        cyc();
        chk("show_2a", 32'(led), 32'h2A);

        // 6: async reset mid-flash
        sum = 7'h11;
        wait_pulse(20, lat);
        sum = 7'h2A;
        wait_pulse(20, lat);
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'h00);
        chk("async_pulse", 32'(new_result), 32'h0);
        run(2);
        rst_n = 1'b1;
        wait_pulse(20, lat);
        chk("lat_rel", 32'(lat), 32'(SETTLE + 1));
        run(FLASH);
        chk("rel_2a", 32'(led), 32'h2A);

        // Randomized holds and values, with occasional resets
        for (int k = 0; k < 400; k++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = m_shown;
            {carry, sum} = v;
            hold = $urandom_range(1, 14);
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                run($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            run(hold);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
